breadboard_sweeper: RTL and testbench

Sequential stimulus/capture stage placed directly around the 4-input combinational logic-gate breadboard. Steps the breadboard inputs (w,x,y,z) through all 16 truth-table rows and waits a programmable settle time per row. Captures the breadboard's function outputs into a 16-entry result table, which a host or bench reads back. Replaces the hand-written delay loop used to tabulate the gate outputs with a synthesizable, clocked engine.

---
 rtl/breadboard_pkg.sv | 28 ++
 rtl/breadboard_sweeper_if.sv | 44 ++++
 rtl/sweep_capture_mem.sv | 38 +++
 rtl/breadboard_sweeper.sv | 137 +++++++++++++
 tb/tb_breadboard_sweeper.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/breadboard_pkg.sv
// -----------------------------------------------------------------------------
// breadboard_pkg
// Shared constants, FSM state type and signature helper for the breadboard
// sweeper. Imported by the interface, the capture memory and the top level.
// Optional feature macro (used by the importers): SWEEP_SIGNATURE_EN
// -----------------------------------------------------------------------------
package breadboard_pkg;

    localparam int NUM_ROWS = 16;   // truth-table rows for 4 inputs
    localparam int IDX_W    = 4;    // row index width
    localparam int SIG_W    = 16;   // sweep signature width
    localparam int CNT_W    = 8;    // settle counter width (SETTLE_CYCLES <= 255)

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Rotate-left-by-one then fold in the (zero-extended) captured row.
    function automatic logic [SIG_W-1:0] sig_next(input logic [SIG_W-1:0] s,
                                                  input logic [SIG_W-1:0] f);
        return {s[SIG_W-2:0], s[SIG_W-1]} ^ f;
    endfunction

endpackage

// File: rtl/breadboard_sweeper_if.sv
// -----------------------------------------------------------------------------
// breadboard_sweeper_if
// Bundles the sweeper's control, breadboard drive/sense and readback signals.
//   slave  : the sweeper (drives w,x,y,z, status, strobes, rd_data, sig)
//   master : host / bench (drives start, rd_addr; breadboard drives f_in)
// Optional macro SWEEP_SIGNATURE_EN adds the 16-bit sig output.
// -----------------------------------------------------------------------------
interface breadboard_sweeper_if #(
    parameter int NUM_OUT = 10
);
    logic                            start;
    logic                            w;
    logic                            x;
    logic                            y;
    logic                            z;
    logic [NUM_OUT-1:0]              f_in;
    logic                            busy;
    logic                            done;
    logic                            row_valid;
    logic [breadboard_pkg::IDX_W-1:0] row_index;
    logic [NUM_OUT-1:0]              row_data;
    logic [breadboard_pkg::IDX_W-1:0] rd_addr;
    logic [NUM_OUT-1:0]              rd_data;
`ifdef SWEEP_SIGNATURE_EN
    logic [breadboard_pkg::SIG_W-1:0] sig;
`endif

    modport slave (
`ifdef SWEEP_SIGNATURE_EN
        output sig,
`endif
        input  start, f_in, rd_addr,
        output w, x, y, z, busy, done, row_valid, row_index, row_data, rd_data
    );

    modport master (
`ifdef SWEEP_SIGNATURE_EN
        input  sig,
`endif
        output start, f_in, rd_addr,
        input  w, x, y, z, busy, done, row_valid, row_index, row_data, rd_data
    );

endinterface

// File: rtl/sweep_capture_mem.sv
// -----------------------------------------------------------------------------
// sweep_capture_mem
// 16 x NUM_OUT result table: synchronous write, combinational read,
// synchronous clear while rst is high.
// Ports: clk, rst, i_we, i_waddr, i_wdata (write side);
//        i_raddr -> o_rdata (asynchronous read side).
// -----------------------------------------------------------------------------
module sweep_capture_mem
    import breadboard_pkg::*;
#(
    parameter int NUM_OUT = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_we,
    input  logic [IDX_W-1:0]   i_waddr,
    input  logic [NUM_OUT-1:0] i_wdata,
    input  logic [IDX_W-1:0]   i_raddr,
    output logic [NUM_OUT-1:0] o_rdata
);

    logic [NUM_OUT-1:0] r_mem [NUM_ROWS];

    // Table storage: cleared by reset, one row written per capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                r_mem[i] <= {NUM_OUT{1'b0}};
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // A read of the row being written sees the old value until the edge.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/breadboard_sweeper.sv
// -----------------------------------------------------------------------------
// breadboard_sweeper
// Steps the 4-input breadboard through all 16 rows, waits SETTLE_CYCLES per
// row, captures f_in into a result table and strobes each captured row.
// Ports: clk, rst (sync, active-high), bus (breadboard_sweeper_if.slave):
//   start, w/x/y/z, f_in, busy, done, row_valid/row_index/row_data,
//   rd_addr/rd_data, and sig when SWEEP_SIGNATURE_EN is defined.
// Optional macro: SWEEP_SIGNATURE_EN (16-bit rotate/xor signature of a sweep).
// -----------------------------------------------------------------------------
module breadboard_sweeper
    import breadboard_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_OUT       = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    breadboard_sweeper_if.slave  bus
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("breadboard_sweeper: SETTLE_CYCLES must be 1..255");
    end
    if (NUM_OUT < 1 || NUM_OUT > 16) begin : g_bad_num_out
        $error("breadboard_sweeper: NUM_OUT must be 1..16");
    end

    localparam logic [CNT_W-1:0] LP_SETTLE = CNT_W'(SETTLE_CYCLES);

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_wxyz;
    logic               r_busy;
    logic               r_done;
    logic               r_row_valid;
    logic [IDX_W-1:0]   r_row_index;
    logic [NUM_OUT-1:0] r_row_data;
    logic               w_we;
    logic [NUM_OUT-1:0] w_rd_data;
`ifdef SWEEP_SIGNATURE_EN
    logic [SIG_W-1:0]   r_sig;
`endif

    // Sweep FSM with row index, settle counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= {IDX_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_wxyz      <= 4'b0000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_row_valid <= 1'b0;
            r_row_index <= {IDX_W{1'b0}};
            r_row_data  <= {NUM_OUT{1'b0}};
`ifdef SWEEP_SIGNATURE_EN
            r_sig       <= {SIG_W{1'b0}};
`endif
        end else begin
            r_row_valid <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_idx   <= {IDX_W{1'b0}};
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= DRIVE;
`ifdef SWEEP_SIGNATURE_EN
                        r_sig   <= {SIG_W{1'b0}};
`endif
                    end
                end
                DRIVE: begin
                    r_wxyz  <= r_idx;
                    r_cnt   <= LP_SETTLE;
                    r_state <= SETTLE;
                end
                SETTLE: begin
                    // Leaving on count==1 gives exactly SETTLE_CYCLES here.
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_row_valid <= 1'b1;
                    r_row_index <= r_idx;
                    r_row_data  <= bus.f_in;
`ifdef SWEEP_SIGNATURE_EN
                    r_sig       <= sig_next(r_sig, SIG_W'(bus.f_in));
`endif
                    if (r_idx == IDX_W'(NUM_ROWS - 1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= DRIVE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_we = (r_state == CAPTURE);

    sweep_capture_mem #(
        .NUM_OUT (NUM_OUT)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (bus.f_in),
        .i_raddr (bus.rd_addr),
        .o_rdata (w_rd_data)
    );

    assign bus.w         = r_wxyz[3];
    assign bus.x         = r_wxyz[2];
    assign bus.y         = r_wxyz[1];
    assign bus.z         = r_wxyz[0];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.row_valid = r_row_valid;
    assign bus.row_index = r_row_index;
    assign bus.row_data  = r_row_data;
    assign bus.rd_data   = w_rd_data;
`ifdef SWEEP_SIGNATURE_EN
    assign bus.sig       = r_sig;
`endif

endmodule

// File: tb/tb_breadboard_sweeper.sv
// -----------------------------------------------------------------------------
// tb_breadboard_sweeper
// Directed bench: dut_a uses SETTLE_CYCLES=4, dut_b uses SETTLE_CYCLES=1.
// Both drive a behavioural breadboard with f0 = x|(~y&z) and
// f2 = (w&x&y&z)|(~w&~x&~y&~z). Signature checks exist when
// SWEEP_SIGNATURE_EN is defined.
// -----------------------------------------------------------------------------
module tb_breadboard_sweeper;

    // Hand-tabulated truth tables of f0 and f2 (bit r = row r).
    localparam logic [15:0] F0_MASK = 16'hF2F2;
    localparam logic [15:0] F2_MASK = 16'h8001;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_total = 0;
    int n_bad   = 0;

    breadboard_sweeper_if #(.NUM_OUT(10)) a_if();
    breadboard_sweeper_if #(.NUM_OUT(10)) b_if();

    breadboard_sweeper #(.SETTLE_CYCLES(4), .NUM_OUT(10)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    breadboard_sweeper #(.SETTLE_CYCLES(1), .NUM_OUT(10)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Breadboard gate logic seen by each sweeper.
    function automatic logic [9:0] bb_func(input logic w, input logic x,
                                           input logic y, input logic z);
        logic [9:0] f;
        f    = 10'd0;
        f[0] = x | (~y & z);
        f[2] = (w & x & y & z) | (~w & ~x & ~y & ~z);
        return f;
    endfunction

    assign a_if.f_in = bb_func(a_if.w, a_if.x, a_if.y, a_if.z);
    assign b_if.f_in = bb_func(b_if.w, b_if.x, b_if.y, b_if.z);

    // Expected table entry for a row, from the hand tables.
    function automatic logic [9:0] exp_row(input int r);
        logic [15:0] m0;
        logic [15:0] m2;
        logic [9:0]  e;
        m0   = F0_MASK;
        m2   = F2_MASK;
        e    = 10'd0;
        e[0] = m0[r];
        e[2] = m2[r];
        return e;
    endfunction

    function automatic logic [15:0] sig_ref();
        logic [15:0] s;
        s = 16'd0;
        for (int r = 0; r < 16; r++) begin
            s = {s[14:0], s[15]} ^ {6'd0, exp_row(r)};
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Row-strobe monitor on dut_a.
    logic mon_en  = 1'b0;
    int   mon_idx = 0;
    int   mon_cnt = 0;
    always @(negedge clk) begin
        if (mon_en && a_if.row_valid) begin
            check("strobe_index", 32'(a_if.row_index), mon_idx);
            check("strobe_wxyz", 32'({a_if.w, a_if.x, a_if.y, a_if.z}), mon_idx);
            check("strobe_data", 32'(a_if.row_data), 32'(exp_row(mon_idx)));
            mon_idx++;
            mon_cnt++;
        end
    end

    // Pulse start for one edge; returns half a cycle after the sampling edge.
    task automatic start_pulse(input bit sel);
        if (sel) b_if.start = 1'b1; else a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
        b_if.start = 1'b0;
    endtask

    // Counts edges until done; optionally re-pulses start mid-sweep.
    task automatic wait_done(input bit sel, input int inj1, input int inj2,
                             output int k);
        k = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if ((sel ? b_if.done : a_if.done) == 1'b1) begin
                k = i;
                a_if.start = 1'b0;
                b_if.start = 1'b0;
                break;
            end
            if (sel) b_if.start = (i == inj1 || i == inj2);
            else     a_if.start = (i == inj1 || i == inj2);
        end
    endtask

    task automatic check_table_a(input string tag, input bit zero);
        for (int r = 0; r < 16; r++) begin
            a_if.rd_addr = 4'(r);
            #1;
            check(tag, 32'(a_if.rd_data), zero ? 32'd0 : 32'(exp_row(r)));
        end
    endtask

    // Safety net against a hung run.
    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        a_if.start = 1'b0;  b_if.start = 1'b0;
        a_if.rd_addr = 4'd0; b_if.rd_addr = 4'd0;

        // Reset held two cycles.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(a_if.busy), 32'd0);
        check("rst_done", 32'(a_if.done), 32'd0);
        check("rst_row_valid", 32'(a_if.row_valid), 32'd0);
        check("rst_row_index", 32'(a_if.row_index), 32'd0);
        check("rst_row_data", 32'(a_if.row_data), 32'd0);
        check("rst_wxyz", 32'({a_if.w, a_if.x, a_if.y, a_if.z}), 32'd0);
        check("rst_b_busy", 32'(b_if.busy), 32'd0);
        check("rst_b_rd_data", 32'(b_if.rd_data), 32'd0);
`ifdef SWEEP_SIGNATURE_EN
        check("rst_b_sig", 32'(b_if.sig), 32'd0);
`endif
        check_table_a("rst_table", 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Idle with start low.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(a_if.busy), 32'd0);
        end

        // Full sweep.
        mon_idx = 0; mon_cnt = 0; mon_en = 1'b1;
        start_pulse(1'b0);
        check("sweep1_busy", 32'(a_if.busy), 32'd1);
        check("sweep1_done", 32'(a_if.done), 32'd0);
        wait_done(1'b0, -1, -1, k);
        check("sweep1_cycles", k, 32'd96);
        @(negedge clk);
        check("sweep1_strobes", mon_cnt, 32'd16);
        check("sweep1_busy_end", 32'(a_if.busy), 32'd0);
        check("sweep1_wxyz_hold", 32'({a_if.w, a_if.x, a_if.y, a_if.z}), 32'hF);
        check_table_a("sweep1_table", 1'b0);

        // Restart from DONE; starts mid-sweep are ignored.
        @(negedge clk);
        mon_idx = 0; mon_cnt = 0;
        start_pulse(1'b0);
        check("restart_done_clr", 32'(a_if.done), 32'd0);
        check("restart_busy", 32'(a_if.busy), 32'd1);
        wait_done(1'b0, 10, 50, k);
        check("sweep2_cycles", k, 32'd96);
        @(negedge clk);
        check("sweep2_strobes", mon_cnt, 32'd16);
        mon_en = 1'b0;

        // Reset during row 7 CAPTURE (sampled at edge 48).
        start_pulse(1'b0);
        repeat (47) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(a_if.busy), 32'd0);
        check("midrst_done", 32'(a_if.done), 32'd0);
        check("midrst_row_valid", 32'(a_if.row_valid), 32'd0);
        check("midrst_wxyz", 32'({a_if.w, a_if.x, a_if.y, a_if.z}), 32'd0);
        check_table_a("midrst_table", 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_idle", 32'(a_if.busy), 32'd0);

        // SETTLE_CYCLES=1 instance: two sweeps, identical signatures.
        for (int s = 0; s < 2; s++) begin
            start_pulse(1'b1);
`ifdef SWEEP_SIGNATURE_EN
            check("b_sig_cleared", 32'(b_if.sig), 32'd0);
`endif
            wait_done(1'b1, -1, -1, k);
            check("b_cycles", k, 32'd48);
`ifdef SWEEP_SIGNATURE_EN
            check("b_sig", 32'(b_if.sig), 32'(sig_ref()));
`endif
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
